// File: rtl/alu_issue_ctrl.sv
// Issue/capture stage in front of a combinational ALU.
// Decodes one MIPS instruction per handshake, drives the ALU from registers,
// captures OUT/ZERO one cycle later and holds the result until writeback takes it.
module alu_issue_ctrl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned OPRN_WIDTH     = 6,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      REQ_VALID,
    output logic                      REQ_READY,
    input  logic [5:0]                REQ_OPCODE,
    input  logic [5:0]                REQ_FUNCT,
    input  logic [4:0]                REQ_SHAMT,
    input  logic [15:0]               REQ_IMM,
    input  logic [DATA_WIDTH-1:0]     REQ_RS_DATA,
    input  logic [DATA_WIDTH-1:0]     REQ_RT_DATA,
    input  logic [REG_ADDR_WIDTH-1:0] REQ_DEST,
    output logic [DATA_WIDTH-1:0]     ALU_OP1,
    output logic [DATA_WIDTH-1:0]     ALU_OP2,
    output logic [OPRN_WIDTH-1:0]     ALU_OPRN,
    input  logic [DATA_WIDTH-1:0]     ALU_OUT,
    input  logic                      ALU_ZERO,
    output logic                      RES_VALID,
    input  logic                      RES_READY,
    output logic [DATA_WIDTH-1:0]     RES_DATA,
    output logic                      RES_ZERO,
    output logic [REG_ADDR_WIDTH-1:0] RES_DEST,
    output logic                      RES_ILLEGAL
);

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // R-type funct codes
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_MUL = 6'h2C;

    // ALU operation codes
    localparam logic [OPRN_WIDTH-1:0] OPRN_NONE = OPRN_WIDTH'(0);
    localparam logic [OPRN_WIDTH-1:0] OPRN_ADD  = OPRN_WIDTH'(1);
    localparam logic [OPRN_WIDTH-1:0] OPRN_SUB  = OPRN_WIDTH'(2);
    localparam logic [OPRN_WIDTH-1:0] OPRN_MUL  = OPRN_WIDTH'(3);
    localparam logic [OPRN_WIDTH-1:0] OPRN_SRL  = OPRN_WIDTH'(4);
    localparam logic [OPRN_WIDTH-1:0] OPRN_SLL  = OPRN_WIDTH'(5);
    localparam logic [OPRN_WIDTH-1:0] OPRN_AND  = OPRN_WIDTH'(6);
    localparam logic [OPRN_WIDTH-1:0] OPRN_OR   = OPRN_WIDTH'(7);
    localparam logic [OPRN_WIDTH-1:0] OPRN_NOR  = OPRN_WIDTH'(8);
    localparam logic [OPRN_WIDTH-1:0] OPRN_SLT  = OPRN_WIDTH'(9);

    // lui is executed as a left shift of the immediate by 16
    localparam logic [DATA_WIDTH-1:0] LUI_SHIFT = DATA_WIDTH'(16);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t                      state;
    logic                        req_ready_q;
    logic [DATA_WIDTH-1:0]       alu_op1_q;
    logic [DATA_WIDTH-1:0]       alu_op2_q;
    logic [OPRN_WIDTH-1:0]       alu_oprn_q;
    logic                        illegal_q;
    logic [REG_ADDR_WIDTH-1:0]   dest_q;
    logic                        res_valid_q;
    logic [DATA_WIDTH-1:0]       res_data_q;
    logic                        res_zero_q;
    logic [REG_ADDR_WIDTH-1:0]   res_dest_q;
    logic                        res_illegal_q;

    logic [OPRN_WIDTH-1:0]       dec_oprn;
    logic [DATA_WIDTH-1:0]       dec_op1;
    logic [DATA_WIDTH-1:0]       dec_op2;
    logic                        dec_illegal;
    logic [DATA_WIDTH-1:0]       imm_sext;
    logic [DATA_WIDTH-1:0]       imm_zext;
    logic [DATA_WIDTH-1:0]       shamt_zext;

    assign imm_sext   = DATA_WIDTH'($signed(REQ_IMM));
    assign imm_zext   = DATA_WIDTH'(REQ_IMM);
    assign shamt_zext = DATA_WIDTH'(REQ_SHAMT);

    // Decode the presented instruction into ALU operation and operands
    always_comb begin
        dec_oprn    = OPRN_NONE;
        dec_op1     = REQ_RS_DATA;
        dec_op2     = REQ_RT_DATA;
        dec_illegal = 1'b0;
        case (REQ_OPCODE)
            OP_RTYPE: begin
                case (REQ_FUNCT)
                    FN_ADD: dec_oprn = OPRN_ADD;
                    FN_SUB: dec_oprn = OPRN_SUB;
                    FN_MUL: dec_oprn = OPRN_MUL;
                    FN_AND: dec_oprn = OPRN_AND;
                    FN_OR:  dec_oprn = OPRN_OR;
                    FN_NOR: dec_oprn = OPRN_NOR;
                    FN_SLT: dec_oprn = OPRN_SLT;
                    FN_SRL: begin
                        dec_oprn = OPRN_SRL;
                        dec_op1  = REQ_RT_DATA;
                        dec_op2  = shamt_zext;
                    end
                    FN_SLL: begin
                        dec_oprn = OPRN_SLL;
                        dec_op1  = REQ_RT_DATA;
                        dec_op2  = shamt_zext;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                dec_oprn = OPRN_ADD;
                dec_op2  = imm_sext;
            end
            OP_SLTI: begin
                dec_oprn = OPRN_SLT;
                dec_op2  = imm_sext;
            end
            OP_ANDI: begin
                dec_oprn = OPRN_AND;
                dec_op2  = imm_zext;
            end
            OP_ORI: begin
                dec_oprn = OPRN_OR;
                dec_op2  = imm_zext;
            end
            OP_LUI: begin
                dec_oprn = OPRN_SLL;
                dec_op1  = imm_zext;
                dec_op2  = LUI_SHIFT;
            end
            default: dec_illegal = 1'b1;
        endcase
        // Illegal requests present a neutral all-zero operation to the ALU
        if (dec_illegal) begin
            dec_oprn = OPRN_NONE;
            dec_op1  = '0;
            dec_op2  = '0;
        end
    end

    // IDLE -> EXEC -> DONE -> IDLE sequencer with all outputs registered
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state         <= IDLE;
            req_ready_q   <= 1'b1;
            alu_op1_q     <= '0;
            alu_op2_q     <= '0;
            alu_oprn_q    <= '0;
            illegal_q     <= 1'b0;
            dest_q        <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_zero_q    <= 1'b0;
            res_dest_q    <= '0;
            res_illegal_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        alu_op1_q   <= dec_op1;
                        alu_op2_q   <= dec_op2;
                        alu_oprn_q  <= dec_oprn;
                        illegal_q   <= dec_illegal;
                        dest_q      <= REQ_DEST;
                        req_ready_q <= 1'b0;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU inputs have been stable for the whole cycle; take its result
                    res_data_q    <= illegal_q ? '0 : ALU_OUT;
                    res_zero_q    <= illegal_q ? 1'b0 : ALU_ZERO;
                    res_illegal_q <= illegal_q;
                    res_dest_q    <= dest_q;
                    res_valid_q   <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (RES_READY) begin
                        res_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign REQ_READY   = req_ready_q;
    assign ALU_OP1     = alu_op1_q;
    assign ALU_OP2     = alu_op2_q;
    assign ALU_OPRN    = alu_oprn_q;
    assign RES_VALID   = res_valid_q;
    assign RES_DATA    = res_data_q;
    assign RES_ZERO    = res_zero_q;
    assign RES_DEST    = res_dest_q;
    assign RES_ILLEGAL = res_illegal_q;

endmodule
